// File: rtl/disp_pkg.sv
// Shared types, widths and helpers for the seven-segment display arbiter.
package disp_pkg;

  localparam int DIGIT_W = 4;
  localparam int DISP_W  = 16;
  localparam int NDIGITS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } disp_arb_state_t;

  // Round-robin pick over up to 8 requesters; searches upward from last_idx+1 and
  // wraps modulo nreq explicitly so non-power-of-2 requester counts work.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] last_idx,
                                         input int         nreq);
    int         idx;
    logic [2:0] win;
    logic       found;
    win   = last_idx;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i <= nreq && !found) begin
        idx = int'(last_idx) + i;
        if (idx >= nreq) idx = idx - nreq;
        if (req[idx[2:0]]) begin
          win   = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

  // Leading-zero nibbles from the MSB down are blanked; digit 0 always shows.
  function automatic logic [NDIGITS-1:0] blank_mask(input logic [DISP_W-1:0] d);
    logic [NDIGITS-1:0] m;
    logic               lead;
    m    = '0;
    lead = 1'b1;
    for (int k = NDIGITS - 1; k >= 1; k--) begin
      if (lead && d[k*DIGIT_W +: DIGIT_W] == '0) m[k] = 1'b1;
      else lead = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// Requester/display-side bundle of the display arbiter.
interface disp_arbiter_if #(parameter int NREQ = 4);
  import disp_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ*DISP_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic [DISP_W-1:0]      disp_data;
  logic                   busy;
  logic                   scan_tick;
  logic [NDIGITS-1:0]     blank;

  modport master (output req, req_data,
                  input  gnt, disp_data, busy, scan_tick, blank);
  modport slave  (input  req, req_data,
                  output gnt, disp_data, busy, scan_tick, blank);
endinterface

// File: rtl/disp_prescaler.sv
// Free-running scan prescaler; scan_tick pulses one cycle every PRESC clocks.
module disp_prescaler #(
  parameter int PRESC = 16
) (
  input  logic clk,
  input  logic reset,
  output logic scan_tick
);
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0] presc_cnt;

  // Tick is pre-decoded one count early so it coincides with presc_cnt==PRESC-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
      scan_tick <= 1'b0;
    end else begin
      presc_cnt <= (presc_cnt == PW'(PRESC - 1)) ? '0 : presc_cnt + PW'(1);
      scan_tick <= (presc_cnt == PW'(PRESC - 2));
    end
  end
endmodule

// File: rtl/disp_arbiter.sv
// Round-robin, fixed-window arbiter for the 4-digit display plus scan tick.
// Optional leading-zero blanking is enabled by defining DISP_BLANK_EN.
//
// state | meaning
// IDLE  | no window active, gnt=0, disp_data holds last value
// SHOW  | window of HOLD_CYCLES cycles for the granted requester
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 1024,
  parameter int PRESC       = 16
) (
  input  logic          clk,
  input  logic          reset,
  disp_arbiter_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  disp_arb_state_t    state_q, state_n;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_n;
  logic [IDX_W-1:0]   last_idx_q, last_idx_n;
  logic [NREQ-1:0]    gnt_q, gnt_n;
  logic [DISP_W-1:0]  disp_q, disp_n;
  logic               busy_q, busy_n;
  logic [IDX_W-1:0]   win_sel;
  logic               arb;

  assign win_sel = IDX_W'(rr_pick(8'(bus.req), 3'(last_idx_q), NREQ));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      last_idx_q <= IDX_W'(NREQ - 1);
      gnt_q      <= '0;
      disp_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      hold_cnt_q <= hold_cnt_n;
      last_idx_q <= last_idx_n;
      gnt_q      <= gnt_n;
      disp_q     <= disp_n;
      busy_q     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    hold_cnt_n = hold_cnt_q;
    last_idx_n = last_idx_q;
    gnt_n      = gnt_q;
    disp_n     = disp_q;
    busy_n     = busy_q;
    arb        = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req) arb = 1'b1;
      end
      SHOW: begin
        if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
          if (|bus.req) begin
            arb = 1'b1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
          end
        end else begin
          hold_cnt_n = hold_cnt_q + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // A grant edge is the only place request data is sampled.
    if (arb) begin
      gnt_n          = '0;
      gnt_n[win_sel] = 1'b1;
      disp_n         = bus.req_data[int'(win_sel)*DISP_W +: DISP_W];
      last_idx_n     = win_sel;
      hold_cnt_n     = '0;
      busy_n         = 1'b1;
      state_n        = SHOW;
    end
  end

`ifdef DISP_BLANK_EN
  logic [NDIGITS-1:0] blank_q;

  always_ff @(posedge clk) begin
    if (reset)    blank_q <= '0;
    else if (arb) blank_q <= blank_mask(disp_n);
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

  disp_prescaler #(.PRESC(PRESC)) u_presc (
    .clk       (clk),
    .reset     (reset),
    .scan_tick (bus.scan_tick)
  );

  assign bus.gnt       = gnt_q;
  assign bus.disp_data = disp_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_disp_arbiter.sv
// Directed self-checking bench for disp_arbiter (HOLD_CYCLES=8, PRESC=4).
module tb_disp_arbiter;
  logic clk;
  logic reset;
  int   vectors;
  int   errors;

  disp_arbiter_if #(.NREQ(4)) bus ();

  disp_arbiter #(.NREQ(4), .HOLD_CYCLES(8), .PRESC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DISP_BLANK_EN
  localparam logic [3:0] EXP_B0040 = 4'b1100;
  localparam logic [3:0] EXP_B0000 = 4'b1110;
`else
  localparam logic [3:0] EXP_B0040 = 4'b0000;
  localparam logic [3:0] EXP_B0000 = 4'b0000;
`endif
  localparam logic [3:0] EXP_B1000 = 4'b0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_data(input int i, input logic [15:0] v);
    bus.req_data[16*i +: 16] = v;
  endtask

  task automatic sync_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [15:0] d3 [4];

  initial begin
    vectors      = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    d3[0] = 16'hA000; d3[1] = 16'hB000; d3[2] = 16'hC000; d3[3] = 16'hD000;

    // 1: reset values and scan tick cadence
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_gnt",  32'(bus.gnt), 32'h0);
    chk("rst_disp", 32'(bus.disp_data), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_tick", 32'(bus.scan_tick), 32'h0);
    chk("rst_blank", 32'(bus.blank), 32'h0);
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk($sformatf("scan_tick_c%0d", n), 32'(bus.scan_tick), (n % 4 == 3) ? 32'h1 : 32'h0);
    end

    // 2: single one-cycle request, full window then idle
    bus.req = 4'b0001;
    set_data(0, 16'h1234);
    tick();
    bus.req = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("t2_gnt_c%0d", c), 32'(bus.gnt), 32'h1);
      chk($sformatf("t2_busy_c%0d", c), 32'(bus.busy), 32'h1);
      chk($sformatf("t2_disp_c%0d", c), 32'(bus.disp_data), 32'h1234);
      tick();
    end
    chk("t2_idle_gnt", 32'(bus.gnt), 32'h0);
    chk("t2_idle_busy", 32'(bus.busy), 32'h0);
    chk("t2_idle_disp", 32'(bus.disp_data), 32'h1234);

    // 3: all four requesting, rotating grants back to back
    sync_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, d3[i]);
    tick();
    for (int w = 0; w < 5; w++) begin
      for (int c = 0; c < 8; c++) begin
        chk($sformatf("t3_gnt_w%0d_c%0d", w, c), 32'(bus.gnt), 32'(4'b0001 << (w % 4)));
        chk($sformatf("t3_disp_w%0d_c%0d", w, c), 32'(bus.disp_data), 32'(d3[w % 4]));
        chk($sformatf("t3_busy_w%0d_c%0d", w, c), 32'(bus.busy), 32'h1);
        tick();
      end
    end
    bus.req = 4'b0000;

    // 4: mid-window data change ignored until reload
    sync_reset();
    bus.req = 4'b0010;
    set_data(1, 16'h0011);
    tick();
    for (int c = 0; c < 8; c++) begin
      if (c == 3) set_data(1, 16'h0022);
      chk($sformatf("t4_gnt_c%0d", c), 32'(bus.gnt), 32'h2);
      chk($sformatf("t4_disp_c%0d", c), 32'(bus.disp_data), 32'h0011);
      tick();
    end
    chk("t4_reload_gnt", 32'(bus.gnt), 32'h2);
    chk("t4_reload_disp", 32'(bus.disp_data), 32'h0022);
    chk("t4_reload_busy", 32'(bus.busy), 32'h1);
    bus.req = 4'b0000;

    // 5: reset in the middle of a window, then fresh arbitration
    sync_reset();
    bus.req = 4'b0100;
    set_data(2, 16'h5678);
    tick();
    bus.req = 4'b0000;
    tick(3);
    chk("t5_pre_gnt", 32'(bus.gnt), 32'h4);
    chk("t5_pre_disp", 32'(bus.disp_data), 32'h5678);
    reset = 1'b1;
    tick();
    chk("t5_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("t5_rst_disp", 32'(bus.disp_data), 32'h0);
    chk("t5_rst_busy", 32'(bus.busy), 32'h0);
    chk("t5_rst_blank", 32'(bus.blank), 32'h0);
    reset   = 1'b0;
    bus.req = 4'b0101;
    set_data(0, 16'h0A0A);
    set_data(2, 16'h2B2B);
    tick();
    chk("t5_first_gnt", 32'(bus.gnt), 32'h1);
    chk("t5_first_disp", 32'(bus.disp_data), 32'h0A0A);
    tick(8);
    chk("t5_second_gnt", 32'(bus.gnt), 32'h4);
    chk("t5_second_disp", 32'(bus.disp_data), 32'h2B2B);
    bus.req = 4'b0000;

    // 6: blank mask follows each loaded value
    sync_reset();
    bus.req = 4'b0001;
    set_data(0, 16'h0040);
    tick();
    chk("t6_disp_0040", 32'(bus.disp_data), 32'h0040);
    chk("t6_blank_0040", 32'(bus.blank), 32'(EXP_B0040));
    set_data(0, 16'h0000);
    tick(8);
    chk("t6_disp_0000", 32'(bus.disp_data), 32'h0000);
    chk("t6_blank_0000", 32'(bus.blank), 32'(EXP_B0000));
    set_data(0, 16'h1000);
    tick(8);
    chk("t6_disp_1000", 32'(bus.disp_data), 32'h1000);
    chk("t6_blank_1000", 32'(bus.blank), 32'(EXP_B1000));
    bus.req = 4'b0000;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
